// File: rtl/hybrid_subtractor8_pipe.sv
// Two-stage 8-bit subtractor with valid/ready handshaking.
// The low nibble uses borrow lookahead, and the high nibble ripples from the registered B4.
module hybrid_subtractor8_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Xi,
    input  logic [7:0] Yi,
    input  logic       B0,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] Di,
    output logic       B8,
    output logic       V,
    output logic       out_valid,
    input  logic       out_ready
);

    logic       s1_valid;
    logic [3:0] s1_d;
    logic       s1_b4;
    logic [3:0] s1_x;
    logic [3:0] s1_y;

    logic       ld1;
    logic       ld2;
    logic       accept;

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] lb;
    logic [3:0] d_lo;

    logic [4:0] hi_res;
    logic [3:0] d_hi;
    logic       b8_next;
    logic       v_next;

    // Stage 2 can take new data when it is empty or its result is leaving.
    // Stage 1 can take new data when it is empty or its contents move on to stage 2.
    assign ld2      = !out_valid || out_ready;
    assign ld1      = !s1_valid || ld2;
    assign in_ready = ld1;
    assign accept   = in_valid && ld1;

    // Full subtractor cells rippling the borrow through the high nibble.
    // The result is packed as {borrow_out, diff[3:0]}.
    function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                           input logic bin);
        logic [3:0] d;
        logic       b;
        b = bin;
        for (int i = 0; i < 4; i++) begin
            d[i] = x[i] ^ y[i] ^ b;
            b    = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & b);
        end
        return {b, d};
    endfunction

    // Two-level borrow lookahead for the low nibble.
    // Each borrow is a flat sum of products of g, p and B0, so no borrow waits on the previous bit.
    always_comb begin
        g     = ~Xi[3:0] & Yi[3:0];
        p     = ~(Xi[3:0] ^ Yi[3:0]);
        lb[0] = B0;
        lb[1] = g[0] | (p[0] & B0);
        lb[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & B0);
        lb[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & B0);
        lb[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & B0);
        d_lo  = Xi[3:0] ^ Yi[3:0] ^ lb[3:0];
    end

    always_comb begin
        hi_res  = ripple4(s1_x, s1_y, s1_b4);
        d_hi    = hi_res[3:0];
        b8_next = hi_res[4];
        v_next  = (s1_x[3] ^ s1_y[3]) & (s1_x[3] ^ d_hi[3]);
    end

    // Data registers load only when a real operand moves in, so bubbles leave data untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_d     <= 4'h0;
            s1_b4    <= 1'b0;
            s1_x     <= 4'h0;
            s1_y     <= 4'h0;
        end else if (ld1) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_d  <= d_lo;
                s1_b4 <= lb[4];
                s1_x  <= Xi[7:4];
                s1_y  <= Yi[7:4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            Di        <= 8'h00;
            B8        <= 1'b0;
            V         <= 1'b0;
        end else if (ld2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                Di <= {d_hi, s1_d};
                B8 <= b8_next;
                V  <= v_next;
            end
        end
    end

endmodule
